// File: rtl/lif_neuron_multi.sv
// Leaky integrate-and-fire neuron with NUM_IN weighted synapses and saturating membrane.
// Define LIF_REFRACTORY_EN to add the REFRACT state and its down-counter.
//   state      | meaning
//   INTEGRATE  | accumulate weighted spikes, leak, compare against threshold
//   REFRACT    | inputs ignored, v held at 0, counting down REFRACT_CYC edges
module lif_neuron_multi #(
    parameter int NUM_IN      = 4,
    parameter int W_WIDTH     = 8,
    parameter int V_WIDTH     = 16,
    parameter int LEAK_SHIFT  = 3,
    parameter int REFRACT_CYC = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_IN-1:0]          spike_in,
    input  logic [NUM_IN*W_WIDTH-1:0]  weight_in,
    input  logic [V_WIDTH-1:0]         threshold,
    output logic                       spike_out,
    output logic [V_WIDTH-1:0]         membrane,
    output logic                       refractory
);

    localparam int S_WIDTH = V_WIDTH + W_WIDTH + $clog2(NUM_IN);
    localparam logic [V_WIDTH-1:0] V_MAX = '1;

    logic [V_WIDTH-1:0] v_q, v_d;
    logic               spike_q, spike_d;
    logic [S_WIDTH-1:0] sum_w;
    logic [V_WIDTH-1:0] leak;
    logic [S_WIDTH-1:0] v_next;
    logic [V_WIDTH-1:0] v_sat;
    logic               fire;

    always_comb begin
        sum_w = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (spike_in[i]) begin
                sum_w = sum_w + S_WIDTH'(weight_in[i*W_WIDTH +: W_WIDTH]);
            end
        end
        // Small potentials would never leak under a pure shift; force a unit step so v reaches 0.
        leak = v_q >> LEAK_SHIFT;
        if (v_q != '0 && leak == '0) begin
            leak = V_WIDTH'(1);
        end
        v_next = S_WIDTH'(v_q) - S_WIDTH'(leak) + sum_w;
        v_sat  = (v_next > S_WIDTH'(V_MAX)) ? V_MAX : v_next[V_WIDTH-1:0];
        fire   = (threshold != '0) && (v_next >= S_WIDTH'(threshold));
    end

`ifdef LIF_REFRACTORY_EN
    localparam int CNT_W = (REFRACT_CYC > 0) ? $clog2(REFRACT_CYC + 1) : 1;

    typedef enum logic {
        ST_INTEGRATE = 1'b0,
        ST_REFRACT   = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INTEGRATE;
            cnt_q   <= '0;
            v_q     <= '0;
            spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            spike_q <= spike_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        v_d     = v_sat;
        spike_d = 1'b0;
        case (state_q)
            ST_INTEGRATE: begin
                if (fire) begin
                    v_d     = '0;
                    spike_d = 1'b1;
                    // A zero-length refractory period skips REFRACT entirely.
                    if (REFRACT_CYC > 0) begin
                        state_d = ST_REFRACT;
                        cnt_d   = CNT_W'(REFRACT_CYC);
                    end
                end
            end
            ST_REFRACT: begin
                v_d   = '0;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_INTEGRATE;
                end
            end
            default: begin
                state_d = ST_INTEGRATE;
                cnt_d   = '0;
                v_d     = '0;
            end
        endcase
    end

    assign refractory = (state_q == ST_REFRACT);
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q     <= '0;
            spike_q <= 1'b0;
        end else begin
            v_q     <= v_d;
            spike_q <= spike_d;
        end
    end

    always_comb begin
        v_d     = v_sat;
        spike_d = 1'b0;
        if (fire) begin
            v_d     = '0;
            spike_d = 1'b1;
        end
    end

    assign refractory = 1'b0;
`endif

    assign spike_out = spike_q;
    assign membrane  = v_q;

endmodule
